// File: rtl/reservation_station.sv
// reservation_station: out-of-order issue buffer with CDB wakeup and lowest-index select.
// Define RS_LSB_CDB_EN to snoop a second (LSB) broadcast bus in parallel with the ALU CDB.
module reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_WIDTH = 4,
    parameter int OP_WIDTH  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 ROB_clear,
    input  logic                 ISSUE_sgn,
    input  logic [OP_WIDTH-1:0]  ISSUE_opcode,
    input  logic [ROB_WIDTH-1:0] ISSUE_ROB_name,
    input  logic [31:0]          ISSUE_Vj,
    input  logic [ROB_WIDTH-1:0] ISSUE_Qj,
    input  logic                 ISSUE_Rj,
    input  logic [31:0]          ISSUE_Vk,
    input  logic [ROB_WIDTH-1:0] ISSUE_Qk,
    input  logic                 ISSUE_Rk,
    output logic                 RS_full,
    input  logic                 CDB_sgn,
    input  logic [31:0]          CDB_result,
    input  logic [ROB_WIDTH-1:0] CDB_ROB_name,
`ifdef RS_LSB_CDB_EN
    input  logic                 LSB_CDB_sgn,
    input  logic [31:0]          LSB_CDB_result,
    input  logic [ROB_WIDTH-1:0] LSB_CDB_ROB_name,
`endif
    output logic                 ALU_sgn,
    output logic [OP_WIDTH-1:0]  ALU_opcode,
    output logic [ROB_WIDTH-1:0] ALU_ROB_name,
    output logic [31:0]          ALU_lhs,
    output logic [31:0]          ALU_rhs
);
    localparam int IW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]                busy_q, busy_d, rj_q, rj_d, rk_q, rk_d;
    logic [RS_SIZE-1:0][OP_WIDTH-1:0]  op_q, op_d;
    logic [RS_SIZE-1:0][ROB_WIDTH-1:0] dest_q, dest_d, qj_q, qj_d, qk_q, qk_d;
    logic [RS_SIZE-1:0][31:0]          vj_q, vj_d, vk_q, vk_d;
    logic                              alu_sgn_q, alu_sgn_d;
    logic [OP_WIDTH-1:0]               alu_op_q, alu_op_d;
    logic [ROB_WIDTH-1:0]              alu_dest_q, alu_dest_d;
    logic [31:0]                       alu_lhs_q, alu_lhs_d, alu_rhs_q, alu_rhs_d;
    logic [IW-1:0]                     free_idx, sel_idx;
    logic                              sel_v;

    // Returns {ready, value} after snooping the broadcast bus(es); ALU CDB wins a tie.
    function automatic logic [32:0] snoop(input logic r, input logic [ROB_WIDTH-1:0] q,
                                          input logic [31:0] v);
`ifdef RS_LSB_CDB_EN
        return r ? {1'b1, v} : (CDB_sgn && CDB_ROB_name == q) ? {1'b1, CDB_result} :
               (LSB_CDB_sgn && LSB_CDB_ROB_name == q) ? {1'b1, LSB_CDB_result} : {1'b0, v};
`else
        return r ? {1'b1, v} : (CDB_sgn && CDB_ROB_name == q) ? {1'b1, CDB_result} : {1'b0, v};
`endif
    endfunction

    assign RS_full      = &busy_q;
    assign ALU_sgn      = alu_sgn_q;
    assign ALU_opcode   = alu_op_q;
    assign ALU_ROB_name = alu_dest_q;
    assign ALU_lhs      = alu_lhs_q;
    assign ALU_rhs      = alu_rhs_q;

    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        sel_v    = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IW'(i);
            if (busy_q[i] && rj_q[i] && rk_q[i]) begin
                sel_idx = IW'(i);
                sel_v   = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d     = busy_q;
        op_d       = op_q;
        dest_d     = dest_q;
        vj_d       = vj_q;
        qj_d       = qj_q;
        rj_d       = rj_q;
        vk_d       = vk_q;
        qk_d       = qk_q;
        rk_d       = rk_q;
        alu_sgn_d  = 1'b0;
        alu_op_d   = alu_op_q;
        alu_dest_d = alu_dest_q;
        alu_lhs_d  = alu_lhs_q;
        alu_rhs_d  = alu_rhs_q;
        if (rdy && ROB_clear) begin
            busy_d = '0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                {rj_d[i], vj_d[i]} = snoop(rj_q[i], qj_q[i], vj_q[i]);
                {rk_d[i], vk_d[i]} = snoop(rk_q[i], qk_q[i], vk_q[i]);
            end
            if (sel_v) begin
                busy_d[sel_idx] = 1'b0;
                alu_sgn_d       = 1'b1;
                alu_op_d        = op_q[sel_idx];
                alu_dest_d      = dest_q[sel_idx];
                alu_lhs_d       = vj_q[sel_idx];
                alu_rhs_d       = vk_q[sel_idx];
            end
            // free_idx is a pre-edge free slot, so it never aliases the dispatched entry
            if (ISSUE_sgn && !RS_full) begin
                busy_d[free_idx] = 1'b1;
                op_d[free_idx]   = ISSUE_opcode;
                dest_d[free_idx] = ISSUE_ROB_name;
                qj_d[free_idx]   = ISSUE_Qj;
                qk_d[free_idx]   = ISSUE_Qk;
                {rj_d[free_idx], vj_d[free_idx]} = snoop(ISSUE_Rj, ISSUE_Qj, ISSUE_Vj);
                {rk_d[free_idx], vk_d[free_idx]} = snoop(ISSUE_Rk, ISSUE_Qk, ISSUE_Vk);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            op_q       <= '0;
            dest_q     <= '0;
            vj_q       <= '0;
            qj_q       <= '0;
            rj_q       <= '0;
            vk_q       <= '0;
            qk_q       <= '0;
            rk_q       <= '0;
            alu_sgn_q  <= 1'b0;
            alu_op_q   <= '0;
            alu_dest_q <= '0;
            alu_lhs_q  <= '0;
            alu_rhs_q  <= '0;
        end else begin
            busy_q     <= busy_d;
            op_q       <= op_d;
            dest_q     <= dest_d;
            vj_q       <= vj_d;
            qj_q       <= qj_d;
            rj_q       <= rj_d;
            vk_q       <= vk_d;
            qk_q       <= qk_d;
            rk_q       <= rk_d;
            alu_sgn_q  <= alu_sgn_d;
            alu_op_q   <= alu_op_d;
            alu_dest_q <= alu_dest_d;
            alu_lhs_q  <= alu_lhs_d;
            alu_rhs_q  <= alu_rhs_d;
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: randomized and directed checks of reservation_station against a slot-list model.
module tb_reservation_station;
    logic        clk = 0, rst = 1, rdy = 1, ROB_clear = 0, ISSUE_sgn = 0;
    logic [5:0]  ISSUE_opcode = 0;
    logic [3:0]  ISSUE_ROB_name = 0, ISSUE_Qj = 0, ISSUE_Qk = 0, CDB_ROB_name = 0;
    logic [31:0] ISSUE_Vj = 0, ISSUE_Vk = 0, CDB_result = 0;
    logic        ISSUE_Rj = 0, ISSUE_Rk = 0, CDB_sgn = 0;
    logic        RS_full, ALU_sgn;
    logic [5:0]  ALU_opcode;
    logic [3:0]  ALU_ROB_name;
    logic [31:0] ALU_lhs, ALU_rhs;

    reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .ROB_clear(ROB_clear), .ISSUE_sgn(ISSUE_sgn),
        .ISSUE_opcode(ISSUE_opcode), .ISSUE_ROB_name(ISSUE_ROB_name),
        .ISSUE_Vj(ISSUE_Vj), .ISSUE_Qj(ISSUE_Qj), .ISSUE_Rj(ISSUE_Rj),
        .ISSUE_Vk(ISSUE_Vk), .ISSUE_Qk(ISSUE_Qk), .ISSUE_Rk(ISSUE_Rk),
        .RS_full(RS_full), .CDB_sgn(CDB_sgn), .CDB_result(CDB_result), .CDB_ROB_name(CDB_ROB_name),
`ifdef RS_LSB_CDB_EN
        .LSB_CDB_sgn(1'b0), .LSB_CDB_result(32'd0), .LSB_CDB_ROB_name(4'd0),
`endif
        .ALU_sgn(ALU_sgn), .ALU_opcode(ALU_opcode), .ALU_ROB_name(ALU_ROB_name),
        .ALU_lhs(ALU_lhs), .ALU_rhs(ALU_rhs)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        busy;
        bit [5:0]  op;
        bit [3:0]  dest;
        bit [31:0] vj, vk;
        bit        rj, rk;
        bit [3:0]  qj, qk;
    } ent_t;

    ent_t      m[16];
    bit        e_sgn;
    bit [5:0]  e_op;
    bit [3:0]  e_dest;
    bit [31:0] e_lhs, e_rhs;
    int        n_chk = 0, n_fail = 0;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic void model_reset();
        foreach (m[i]) m[i] = '{default: 0};
        e_sgn = 0; e_op = 0; e_dest = 0; e_lhs = 0; e_rhs = 0;
    endfunction

    function automatic bit model_full();
        foreach (m[i]) if (!m[i].busy) return 0;
        return 1;
    endfunction

    function automatic void model_step();
        ent_t n[16];
        int   sel = -1, fr = -1;
        if (rst) begin model_reset(); return; end
        if (!rdy) begin e_sgn = 0; return; end
        if (ROB_clear) begin
            foreach (m[i]) m[i].busy = 0;
            e_sgn = 0;
            return;
        end
        for (int i = 0; i < 16; i++) begin
            if (sel < 0 && m[i].busy && m[i].rj && m[i].rk) sel = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        n = m;
        for (int i = 0; i < 16; i++) if (n[i].busy && CDB_sgn) begin
            if (!n[i].rj && n[i].qj == CDB_ROB_name) begin n[i].vj = CDB_result; n[i].rj = 1; end
            if (!n[i].rk && n[i].qk == CDB_ROB_name) begin n[i].vk = CDB_result; n[i].rk = 1; end
        end
        e_sgn = (sel >= 0);
        if (sel >= 0) begin
            e_op = m[sel].op; e_dest = m[sel].dest; e_lhs = m[sel].vj; e_rhs = m[sel].vk;
            n[sel].busy = 0;
        end
        if (ISSUE_sgn && fr >= 0) begin
            n[fr].busy = 1; n[fr].op = ISSUE_opcode; n[fr].dest = ISSUE_ROB_name;
            n[fr].qj = ISSUE_Qj; n[fr].qk = ISSUE_Qk;
            n[fr].rj = ISSUE_Rj || (CDB_sgn && CDB_ROB_name == ISSUE_Qj);
            n[fr].rk = ISSUE_Rk || (CDB_sgn && CDB_ROB_name == ISSUE_Qk);
            n[fr].vj = (!ISSUE_Rj && n[fr].rj) ? CDB_result : ISSUE_Vj;
            n[fr].vk = (!ISSUE_Rk && n[fr].rk) ? CDB_result : ISSUE_Vk;
        end
        m = n;
    endfunction

    always @(negedge clk) begin
        chk("ALU_sgn", 32'(ALU_sgn), 32'(e_sgn));
        chk("ALU_opcode", 32'(ALU_opcode), 32'(e_op));
        chk("ALU_ROB_name", 32'(ALU_ROB_name), 32'(e_dest));
        chk("ALU_lhs", ALU_lhs, e_lhs);
        chk("ALU_rhs", ALU_rhs, e_rhs);
        chk("RS_full", 32'(RS_full), 32'(model_full()));
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #2;
        ISSUE_sgn = 0; CDB_sgn = 0; ROB_clear = 0; rdy = 1;
    endtask

    task automatic iss(bit [5:0] op, bit [3:0] tag, bit [31:0] vj, bit [3:0] qj, bit rj,
                       bit [31:0] vk, bit [3:0] qk, bit rk);
        ISSUE_sgn = 1; ISSUE_opcode = op; ISSUE_ROB_name = tag;
        ISSUE_Vj = vj; ISSUE_Qj = qj; ISSUE_Rj = rj;
        ISSUE_Vk = vk; ISSUE_Qk = qk; ISSUE_Rk = rk;
    endtask

    task automatic cdb(bit [3:0] t, bit [31:0] v);
        CDB_sgn = 1; CDB_ROB_name = t; CDB_result = v;
    endtask

    initial begin
        model_reset();
        cyc();
        chk("rst_sgn", 32'(ALU_sgn), 0);
        chk("rst_lhs", ALU_lhs, 0);
        chk("rst_full", 32'(RS_full), 0);
        rst = 0;
        // T1: ready op dispatches one cycle after issue, pulse lasts one cycle
        iss(6'd1, 4'd3, 32'd5, 4'd0, 1, 32'd7, 4'd0, 1);
        cyc();
        cyc();
        chk("t1_sgn", 32'(ALU_sgn), 1);
        chk("t1_lhs", ALU_lhs, 5);
        chk("t1_rhs", ALU_rhs, 7);
        chk("t1_name", 32'(ALU_ROB_name), 3);
        cyc();
        chk("t1_pulse", 32'(ALU_sgn), 0);
        chk("t1_hold", ALU_lhs, 5);
        // T2: wakeup by CDB
        iss(6'd2, 4'd5, 32'd0, 4'd2, 0, 32'd1, 4'd0, 1);
        cyc();
        cyc();
        cdb(4'd2, 32'd10);
        cyc();
        chk("t2_wait", 32'(ALU_sgn), 0);
        cyc();
        chk("t2_sgn", 32'(ALU_sgn), 1);
        chk("t2_lhs", ALU_lhs, 10);
        chk("t2_rhs", ALU_rhs, 1);
        // T3: same-cycle bypass
        iss(6'd3, 4'd6, 32'd3, 4'd0, 1, 32'd0, 4'd4, 0);
        cdb(4'd4, 32'h55);
        cyc();
        cyc();
        chk("t3_sgn", 32'(ALU_sgn), 1);
        chk("t3_rhs", ALU_rhs, 32'h55);
        // T4: fill, drop issue while full, then drain in index order
        for (int k = 0; k < 16; k++) begin
            iss(6'd1, 4'(k), 32'd0, 4'd9, 0, 32'(100 + k), 4'd0, 1);
            cyc();
        end
        chk("t4_full", 32'(RS_full), 1);
        chk("t4_nodisp", 32'(ALU_sgn), 0);
        iss(6'd7, 4'd15, 32'd1, 4'd0, 1, 32'd2, 4'd0, 1);
        cdb(4'd9, 32'hAB);
        cyc();
        chk("t4_full_wake", 32'(RS_full), 1);
        for (int k = 0; k < 16; k++) begin
            cyc();
            chk("t4_sgn", 32'(ALU_sgn), 1);
            chk("t4_name", 32'(ALU_ROB_name), 32'(k));
            chk("t4_rhs", ALU_rhs, 32'(100 + k));
            if (k == 0) chk("t4_full_drop", 32'(RS_full), 0);
        end
        cyc();
        chk("t4_empty", 32'(ALU_sgn), 0);
        // T5: flush beats a same-cycle issue
        for (int k = 0; k < 5; k++) begin
            iss(6'd1, 4'(k), 32'd0, 4'd1, 0, 32'(k), 4'd0, 1);
            cyc();
        end
        ROB_clear = 1;
        iss(6'd1, 4'd7, 32'd1, 4'd0, 1, 32'd1, 4'd0, 1);
        cyc();
        chk("t5_full", 32'(RS_full), 0);
        chk("t5_sgn", 32'(ALU_sgn), 0);
        cdb(4'd1, 32'd5);
        cyc();
        cyc();
        chk("t5_nodisp", 32'(ALU_sgn), 0);
        // T6: rdy low holds dispatch
        iss(6'd1, 4'd2, 32'd8, 4'd0, 1, 32'd9, 4'd0, 1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            rdy = 0;
            cyc();
            chk("t6_hold", 32'(ALU_sgn), 0);
        end
        cyc();
        chk("t6_sgn", 32'(ALU_sgn), 1);
        chk("t6_lhs", ALU_lhs, 8);
        // async reset mid-cycle discards waiting entries and clears outputs at once
        for (int k = 0; k < 3; k++) begin
            iss(6'd1, 4'(k), 32'd0, 4'd12, 0, 32'd0, 4'd0, 1);
            cyc();
        end
        #1 rst = 1;
        model_reset();
        #1;
        chk("ar_lhs", ALU_lhs, 0);
        chk("ar_sgn", 32'(ALU_sgn), 0);
        cyc();
        rst = 0;
        cdb(4'd12, 32'd1);
        cyc();
        cyc();
        chk("ar_nodisp", 32'(ALU_sgn), 0);
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(0, 9) != 0);
            ROB_clear = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 1) == 1)
                iss(6'($urandom), 4'($urandom), $urandom, 4'($urandom_range(0, 7)), 1'($urandom),
                    $urandom, 4'($urandom_range(0, 7)), 1'($urandom));
            if ($urandom_range(0, 1) == 1) cdb(4'($urandom_range(0, 7)), $urandom);
            cyc();
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
